// File: rtl/multi_lane_stage_queue_if.sv
// Bundle of producer/consumer signals for the multi-lane stage queue.
// The master modport is the side that pushes lanes in and retires entries.
interface multi_lane_stage_queue_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned IN_W   = 2,
  parameter int unsigned OUT_W  = 2,
  parameter int unsigned DEPTH  = 8
);
  localparam int unsigned DeqW = $clog2(OUT_W + 1);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic                    flush;
  logic [IN_W-1:0]         in_valid;
  logic [IN_W*DATA_W-1:0]  in_data;
  logic                    in_ready;
  logic [OUT_W-1:0]        out_valid;
  logic [OUT_W*DATA_W-1:0] out_data;
  logic [DeqW-1:0]         deq_cnt;
  logic [CntW-1:0]         count;
  logic                    empty;
  logic                    full;

  modport master (
    output flush, in_valid, in_data, deq_cnt,
    input  in_ready, out_valid, out_data, count, empty, full
  );

  modport slave (
    input  flush, in_valid, in_data, deq_cnt,
    output in_ready, out_valid, out_data, count, empty, full
  );
endinterface

// File: rtl/multi_lane_stage_queue.sv
// In-order multi-lane FIFO between two pipeline stages. Producer lanes are
// compacted on entry; the consumer sees the OUT_W oldest entries and retires
// a variable number of them per cycle.
module multi_lane_stage_queue #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned IN_W   = 2,
  parameter int unsigned OUT_W  = 2,
  parameter int unsigned DEPTH  = 8
) (
  input logic                  clk,
  input logic                  resetn,
  multi_lane_stage_queue_if.slave q
);
  // A 1-bit pointer keeps the DEPTH==1 corner legal; wrap is always done via % DEPTH.
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  if (((DEPTH & (DEPTH - 1)) != 0) || (DEPTH < IN_W) || (DEPTH < OUT_W)) begin : g_bad_depth
    $error("multi_lane_stage_queue: DEPTH must be a power of 2 and >= max(IN_W, OUT_W)");
  end

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]   rd_q, rd_d, wr_q, wr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              in_ready;
  logic              accept;
  int unsigned       n_in;
  int unsigned       eff;
  logic [IN_W-1:0]   wr_en;
  logic [PtrW-1:0]   wr_idx [IN_W];

  // Acceptance is gated by pre-dequeue occupancy so the queue cannot overflow.
  always_comb begin
    in_ready = ((DEPTH - 32'(count_q)) >= IN_W);
    accept   = in_ready && !q.flush;
    eff      = (32'(q.deq_cnt) < 32'(count_q)) ? 32'(q.deq_cnt) : 32'(count_q);
  end

  // Compact valid lanes into consecutive slots starting at wr_ptr.
  always_comb begin
    n_in  = 0;
    wr_en = '0;
    for (int i = 0; i < IN_W; i++) begin
      wr_idx[i] = PtrW'((32'(wr_q) + n_in) % DEPTH);
      wr_en[i]  = accept && q.in_valid[i];
      if (q.in_valid[i]) n_in = n_in + 1;
    end
  end

  // Entry storage: not reset, written only on accepted lanes.
  always_ff @(posedge clk) begin
    for (int i = 0; i < IN_W; i++) begin
      if (wr_en[i]) mem_q[wr_idx[i]] <= q.in_data[i*DATA_W +: DATA_W];
    end
  end

  // Pointer/occupancy next state; flush overrides enqueue and dequeue.
  always_comb begin
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;
    if (q.flush) begin
      rd_d    = '0;
      wr_d    = '0;
      count_d = '0;
    end else begin
      rd_d    = PtrW'((32'(rd_q) + eff) % DEPTH);
      wr_d    = PtrW'((32'(wr_q) + (accept ? n_in : 0)) % DEPTH);
      count_d = CntW'(32'(count_q) + (accept ? n_in : 0) - eff);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
    end
  end

  // Consumer view: the OUT_W oldest entries, purely from registered state.
  always_comb begin
    q.in_ready = in_ready;
    q.count    = count_q;
    q.empty    = (count_q == '0);
    q.full     = (count_q == CntW'(DEPTH));
    for (int j = 0; j < OUT_W; j++) begin
      q.out_valid[j]                   = (32'(j) < 32'(count_q));
      q.out_data[j*DATA_W +: DATA_W]   = mem_q[PtrW'((32'(rd_q) + 32'(j)) % DEPTH)];
    end
  end

  a_count_bound: assert property (@(posedge clk) disable iff (!resetn) count_q <= CntW'(DEPTH));

endmodule

// File: tb/tb_multi_lane_stage_queue.sv
// Directed bench for multi_lane_stage_queue with IN_W=OUT_W=2, DEPTH=8.
module tb_multi_lane_stage_queue;
  localparam int unsigned DataW = 64;
  localparam int unsigned InW   = 2;
  localparam int unsigned OutW  = 2;
  localparam int unsigned Depth = 8;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  multi_lane_stage_queue_if #(
    .DATA_W(DataW), .IN_W(InW), .OUT_W(OutW), .DEPTH(Depth)
  ) bus ();

  multi_lane_stage_queue #(
    .DATA_W(DataW), .IN_W(InW), .OUT_W(OutW), .DEPTH(Depth)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .q     (bus)
  );

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  // {count, empty, full, in_ready, out_valid}
  function automatic logic [8:0] st();
    return {bus.count, bus.empty, bus.full, bus.in_ready, bus.out_valid};
  endfunction

  task automatic drive(input logic [1:0] v, input logic [63:0] d0, input logic [63:0] d1,
                       input logic [1:0] deq, input logic fl);
    bus.in_valid = v;
    bus.in_data  = {d1, d0};
    bus.deq_cnt  = deq;
    bus.flush    = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [8:0] got, exp;
    got = st(); exp = {4'd0, 3'b101, 2'b00};
    if (got !== exp) $display("FAIL reset_status got=%h exp=%h", got, exp); else n_pass++;
    n_total++;
    tick();
    got = st();
    if (got !== exp) $display("FAIL reset_idle_status got=%h exp=%h", got, exp); else n_pass++;
    n_total++;
  endtask

  task automatic test_basic_fill();
    logic [8:0] got, exp;
    logic [127:0] gd, ed;
    for (int k = 0; k < 4; k++) begin
      drive(2'b11, 64'(32'h100 + 2*k), 64'(32'h101 + 2*k), 2'd0, 1'b0);
      tick();
      got = st(); exp = {4'(2*k + 2), 1'b0, (k == 3), (k != 3), 2'b11};
      if (got !== exp) $display("FAIL fill_status_%0d got=%h exp=%h", k, got, exp); else n_pass++;
      n_total++;
      gd = bus.out_data; ed = {64'h101, 64'h100};
      if (gd !== ed) $display("FAIL fill_data_%0d got=%h exp=%h", k, gd, ed); else n_pass++;
      n_total++;
    end
    // Full: push is refused, dequeue still proceeds.
    drive(2'b11, 64'hBAD0, 64'hBAD1, 2'd2, 1'b0);
    tick();
    got = st(); exp = {4'd6, 3'b001, 2'b11};
    if (got !== exp) $display("FAIL full_push_status got=%h exp=%h", got, exp); else n_pass++;
    n_total++;
    gd = bus.out_data; ed = {64'h103, 64'h102};
    if (gd !== ed) $display("FAIL full_push_data got=%h exp=%h", gd, ed); else n_pass++;
    n_total++;
    for (int m = 0; m < 2; m++) begin
      drive(2'b00, 64'h0, 64'h0, 2'd2, 1'b0);
      tick();
      gd = bus.out_data; ed = {64'(32'h105 + 2*m), 64'(32'h104 + 2*m)};
      if (gd !== ed) $display("FAIL drain_data_%0d got=%h exp=%h", m, gd, ed); else n_pass++;
      n_total++;
    end
    drive(2'b00, 64'h0, 64'h0, 2'd2, 1'b0);
    tick();
    got = st(); exp = {4'd0, 3'b101, 2'b00};
    if (got !== exp) $display("FAIL drain_empty got=%h exp=%h", got, exp); else n_pass++;
    n_total++;
  endtask

  task automatic test_compaction();
    logic [8:0] got, exp;
    logic [127:0] gd, ed;
    drive(2'b10, 64'hDEAD, 64'h200, 2'd0, 1'b0);
    tick();
    got = st(); exp = {4'd1, 3'b001, 2'b01};
    if (got !== exp) $display("FAIL compact_status1 got=%h exp=%h", got, exp); else n_pass++;
    n_total++;
    gd = {64'h0, bus.out_data[63:0]}; ed = {64'h0, 64'h200};
    if (gd !== ed) $display("FAIL compact_lane0 got=%h exp=%h", gd, ed); else n_pass++;
    n_total++;
    drive(2'b11, 64'h201, 64'h202, 2'd0, 1'b0);
    tick();
    got = st(); exp = {4'd3, 3'b001, 2'b11};
    if (got !== exp) $display("FAIL compact_status3 got=%h exp=%h", got, exp); else n_pass++;
    n_total++;
    gd = bus.out_data; ed = {64'h201, 64'h200};
    if (gd !== ed) $display("FAIL compact_xy got=%h exp=%h", gd, ed); else n_pass++;
    n_total++;
    drive(2'b00, 64'h0, 64'h0, 2'd2, 1'b0);
    tick();
    got = st(); exp = {4'd1, 3'b001, 2'b01};
    if (got !== exp) $display("FAIL compact_status_deq got=%h exp=%h", got, exp); else n_pass++;
    n_total++;
    gd = {64'h0, bus.out_data[63:0]}; ed = {64'h0, 64'h202};
    if (gd !== ed) $display("FAIL compact_z got=%h exp=%h", gd, ed); else n_pass++;
    n_total++;
    drive(2'b00, 64'h0, 64'h0, 2'd1, 1'b0);
    tick();
  endtask

  task automatic test_back_to_back();
    logic [8:0] got, exp;
    logic [127:0] gd, ed;
    for (int k = 0; k < 20; k++) begin
      drive(2'b11, 64'(32'h1000 + 2*k), 64'(32'h1001 + 2*k), 2'd2, 1'b0);
      tick();
      got = st(); exp = {4'd2, 3'b001, 2'b11};
      if (got !== exp) $display("FAIL wrap_status_%0d got=%h exp=%h", k, got, exp); else n_pass++;
      n_total++;
      gd = bus.out_data; ed = {64'(32'h1001 + 2*k), 64'(32'h1000 + 2*k)};
      if (gd !== ed) $display("FAIL wrap_data_%0d got=%h exp=%h", k, gd, ed); else n_pass++;
      n_total++;
    end
    drive(2'b00, 64'h0, 64'h0, 2'd2, 1'b0);
    tick();
  endtask

  task automatic test_over_dequeue();
    logic [8:0] got, exp;
    logic [127:0] gd, ed;
    drive(2'b01, 64'h300, 64'h0, 2'd0, 1'b0);
    tick();
    drive(2'b00, 64'h0, 64'h0, 2'd2, 1'b0);
    tick();
    got = st(); exp = {4'd0, 3'b101, 2'b00};
    if (got !== exp) $display("FAIL overdeq_status got=%h exp=%h", got, exp); else n_pass++;
    n_total++;
    drive(2'b01, 64'h301, 64'h0, 2'd2, 1'b0);
    tick();
    got = st(); exp = {4'd1, 3'b001, 2'b01};
    if (got !== exp) $display("FAIL overdeq_next_status got=%h exp=%h", got, exp); else n_pass++;
    n_total++;
    gd = {64'h0, bus.out_data[63:0]}; ed = {64'h0, 64'h301};
    if (gd !== ed) $display("FAIL overdeq_next_data got=%h exp=%h", gd, ed); else n_pass++;
    n_total++;
    drive(2'b00, 64'h0, 64'h0, 2'd1, 1'b0);
    tick();
  endtask

  task automatic test_flush();
    logic [8:0] got, exp;
    logic [127:0] gd, ed;
    logic [63:0] gm;
    drive(2'b11, 64'h400, 64'h401, 2'd0, 1'b0); tick();
    drive(2'b11, 64'h402, 64'h403, 2'd0, 1'b0); tick();
    drive(2'b01, 64'h404, 64'h0,   2'd0, 1'b0); tick();
    drive(2'b11, 64'h4F0, 64'h4F1, 2'd1, 1'b1);
    #1;
    got = st(); exp = {4'd5, 3'b001, 2'b11};
    if (got !== exp) $display("FAIL flush_cycle_status got=%h exp=%h", got, exp); else n_pass++;
    n_total++;
    tick();
    got = st(); exp = {4'd0, 3'b101, 2'b00};
    if (got !== exp) $display("FAIL flush_after_status got=%h exp=%h", got, exp); else n_pass++;
    n_total++;
    drive(2'b11, 64'h500, 64'h501, 2'd0, 1'b0);
    tick();
    gd = bus.out_data; ed = {64'h501, 64'h500};
    if (gd !== ed) $display("FAIL flush_next_data got=%h exp=%h", gd, ed); else n_pass++;
    n_total++;
    gm = dut.mem_q[0];
    if (gm !== 64'h500) $display("FAIL flush_slot0 got=%h exp=%h", gm, 64'h500); else n_pass++;
    n_total++;
    drive(2'b00, 64'h0, 64'h0, 2'd0, 1'b1);
    tick();
  endtask

  task automatic test_async_reset();
    logic [8:0] got, exp;
    drive(2'b11, 64'h600, 64'h601, 2'd0, 1'b0);
    tick();
    drive(2'b11, 64'h602, 64'h603, 2'd0, 1'b0);
    #2 resetn = 1'b0;
    #1;
    got = st(); exp = {4'd0, 3'b101, 2'b00};
    if (got !== exp) $display("FAIL async_reset_status got=%h exp=%h", got, exp); else n_pass++;
    n_total++;
    drive(2'b00, 64'h0, 64'h0, 2'd0, 1'b0);
    #3 resetn = 1'b1;
    tick();
    got = st();
    if (got !== exp) $display("FAIL post_reset_status got=%h exp=%h", got, exp); else n_pass++;
    n_total++;
  endtask

  initial begin
    drive(2'b00, 64'h0, 64'h0, 2'd0, 1'b0);
    #12 resetn = 1'b1;
    test_reset();
    test_basic_fill();
    test_compaction();
    test_back_to_back();
    test_over_dequeue();
    test_flush();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
